glyph_pixel_gen: RTL and testbench

Parametrised text-mode pixel generator for the VGA path. It maps raw pixel coordinates (Qh, Qv) to a text cell and fetches the cell's character code from an external text RAM. It then fetches the glyph row from an external font ROM and emits one font bit per pixel through a fixed 3-cycle pipeline. It adds three features: integer pixel scaling, per-character blink, and a blinking inverse cursor.

---
 rtl/font_pkg.sv | 26 ++
 rtl/glyph_pixel_gen_if.sv | 22 ++
 rtl/blink_timer.sv | 44 ++++
 rtl/glyph_pixel_gen.sv | 130 +++++++++++++
 tb/tb_glyph_pixel_gen.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/font_pkg.sv
// Shared definitions for the text-mode pixel path.
// Holds the glyph code map of the font ROM, the default glyph geometry and a
// constant-foldable clog2 used to size address and coordinate fields.
package font_pkg;

    localparam int GLYPH_W_DEF = 8;
    localparam int GLYPH_H_DEF = 8;

    typedef enum logic [5:0] {
        NADA        = 6'h00,
        A           = 6'h27,
        ARROW_UP    = 6'h28,
        ARROW_DOWN  = 6'h29,
        ARROW_LEFT  = 6'h2A,
        ARROW_RIGHT = 6'h2B
    } glyph_code_e;

    // Smallest r with 2^r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/glyph_pixel_gen_if.sv
// Fetch bus between the pixel generator and its external memories.
//   char_addr  : text RAM address (row*COLS+col)
//   char_code  : text RAM data, MSB is the blink attribute
//   glyph_addr : font ROM address {code, row_in_glyph}
//   glyph_row  : font ROM data, MSB is the leftmost pixel
// master = pixel generator, slave = memory side.
interface glyph_pixel_gen_if #(
    parameter int CADDR_W = 13,
    parameter int CODE_W  = 6,
    parameter int GADDR_W = 9,
    parameter int GLYPH_W = 8
);
    logic [CADDR_W-1:0] char_addr;
    logic [CODE_W:0]    char_code;
    logic [GADDR_W-1:0] glyph_addr;
    logic [GLYPH_W-1:0] glyph_row;

    modport master (output char_addr, output glyph_addr,
                    input  char_code, input  glyph_row);
    modport slave  (input  char_addr, input  glyph_addr,
                    output char_code, output glyph_row);
endinterface

// File: rtl/blink_timer.sv
// Frame-based blink phase generator.
//   reloj, resetM : pixel clock, async active-high reset
//   frame_start   : one-cycle pulse per frame
//   blink_phase   : toggles every BLINK_FRAMES frame_start pulses
// The phase only moves on frame_start, so it never changes mid-frame.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic reloj,
    input  logic resetM,
    input  logic frame_start,
    output logic blink_phase
);
    localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (cnt_q == LAST) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/glyph_pixel_gen.sv
// Text-mode pixel generator, fixed 3-cycle pipeline.
//   Qh, Qv, px_valid, bit_alarma : pixel position and qualifiers (stage 0)
//   frame_start, blink_en        : blink timing and global enable
//   cursor_en/col/row            : inverse blinking cursor position
//   mem                          : text RAM / font ROM fetch bus
//   BIT_FUENTE, bit_valid        : font pixel and its valid, 3 cycles later
//   blink_phase                  : current blink phase
// Stage 1 issues the text RAM address, stage 2 the font ROM address, stage 3
// selects the bit. Both memories answer within the cycle after their address
// register, so the pipeline never stalls.
module glyph_pixel_gen
    import font_pkg::*;
#(
    parameter int GLYPH_W      = GLYPH_W_DEF,
    parameter int GLYPH_H      = GLYPH_H_DEF,
    parameter int SCALE_LOG2   = 0,
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int CODE_W       = 6,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     reloj,
    input  logic                     resetM,
    input  logic [9:0]               Qh,
    input  logic [9:0]               Qv,
    input  logic                     px_valid,
    input  logic                     frame_start,
    input  logic                     bit_alarma,
    input  logic                     blink_en,
    input  logic                     cursor_en,
    input  logic [clog2(COLS)-1:0]   cursor_col,
    input  logic [clog2(ROWS)-1:0]   cursor_row,
    glyph_pixel_gen_if.master        mem,
    output logic                     BIT_FUENTE,
    output logic                     bit_valid,
    output logic                     blink_phase
);
    localparam int GX_W    = clog2(GLYPH_W);
    localparam int GY_W    = clog2(GLYPH_H);
    localparam int CADDR_W = clog2(COLS * ROWS);
    localparam int GADDR_W = CODE_W + GY_W;

    typedef struct packed {
        logic [GX_W-1:0] px;
        logic            in_range;
        logic            valid;
        logic            alarm;
        logic            cursor;
    } side_t;

    // stage 0: coordinate mapping
    logic [9:0]         sx, sy, col0, row0;
    logic [GX_W-1:0]    px0;
    logic [GY_W-1:0]    ry0;
    logic               in_range0, cursor0;
    logic [CADDR_W-1:0] addr0;

    assign sx        = Qh >> SCALE_LOG2;
    assign sy        = Qv >> SCALE_LOG2;
    assign col0      = sx >> GX_W;
    assign px0       = sx[GX_W-1:0];
    assign row0      = sy >> GY_W;
    assign ry0       = sy[GY_W-1:0];
    assign in_range0 = (col0 < 10'(COLS)) && (row0 < 10'(ROWS));
    assign cursor0   = cursor_en && (col0 == 10'(cursor_col)) && (row0 == 10'(cursor_row));
    assign addr0     = CADDR_W'(row0 * COLS + col0);

    side_t              s1_q, s1_d, s2_q, s2_d;
    logic [GY_W-1:0]    ry1_q, ry1_d;
    logic [CADDR_W-1:0] char_addr_q, char_addr_d;
    logic [GADDR_W-1:0] glyph_addr_q, glyph_addr_d;
    logic               blink_attr_q, blink_attr_d;
    logic               bit_q, bit_d;
    logic               bit_valid_q, bit_valid_d;
    logic               font_bit;

    always_comb begin
        s1_d        = '{px: px0, in_range: in_range0, valid: px_valid,
                        alarm: bit_alarma, cursor: cursor0};
        ry1_d       = ry0;
        char_addr_d = in_range0 ? addr0 : '0;

        s2_d         = s1_q;
        glyph_addr_d = {mem.char_code[CODE_W-1:0], ry1_q};
        blink_attr_d = mem.char_code[CODE_W];

        // GLYPH_W is a power of two, so GLYPH_W-1-px is just ~px.
        font_bit = mem.glyph_row[~s2_q.px];
        if (blink_en && blink_attr_q && blink_phase) font_bit = 1'b0;
        // Cursor inverts after the attribute blink has been applied.
        if (s2_q.cursor && blink_phase) font_bit = ~font_bit;
        bit_d       = font_bit && s2_q.in_range && s2_q.valid && !s2_q.alarm;
        bit_valid_d = s2_q.valid;
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            s1_q         <= '0;
            s2_q         <= '0;
            ry1_q        <= '0;
            char_addr_q  <= '0;
            glyph_addr_q <= '0;
            blink_attr_q <= 1'b0;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            ry1_q        <= ry1_d;
            char_addr_q  <= char_addr_d;
            glyph_addr_q <= glyph_addr_d;
            blink_attr_q <= blink_attr_d;
            bit_q        <= bit_d;
            bit_valid_q  <= bit_valid_d;
        end
    end

    assign mem.char_addr  = char_addr_q;
    assign mem.glyph_addr = glyph_addr_q;
    assign BIT_FUENTE     = bit_q;
    assign bit_valid      = bit_valid_q;

    blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink_timer (
        .reloj       (reloj),
        .resetM      (resetM),
        .frame_start (frame_start),
        .blink_phase (blink_phase)
    );

endmodule

// File: tb/tb_glyph_pixel_gen.sv
// Directed bench for glyph_pixel_gen. Two instances share the stimulus:
// dut_a (no scaling, blink every 2 frames) and dut_b (2x scaling, default
// blink). Each has a small text/font model: text cells 82 and 0 hold tb_code,
// glyph 0x27 row 0 is 0x18, code 0 is blank, anything else reads 0xFF.
module tb_glyph_pixel_gen;

    logic       reloj;
    logic       resetM;
    logic [9:0] Qh, Qv;
    logic       px_valid, frame_start, bit_alarma, blink_en, cursor_en;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;
    logic [6:0] tb_code;

    logic bit_a, valid_a, phase_a;
    logic bit_b, valid_b, phase_b;

    int errors = 0;
    int checks = 0;

    logic        obs_a [32];
    logic        obs_b [32];
    logic        vld_a [32];
    logic        vld_b [32];
    logic [12:0] caddr_a [32];
    logic [12:0] caddr_b [32];
    logic [8:0]  gaddr_a [32];
    logic [8:0]  gaddr_b [32];

    glyph_pixel_gen_if #(.CADDR_W(13), .CODE_W(6), .GADDR_W(9), .GLYPH_W(8)) mem_a ();
    glyph_pixel_gen_if #(.CADDR_W(13), .CODE_W(6), .GADDR_W(9), .GLYPH_W(8)) mem_b ();

    assign mem_a.char_code = (mem_a.char_addr == 13'd82 || mem_a.char_addr == 13'd0) ? tb_code : 7'h00;
    assign mem_b.char_code = (mem_b.char_addr == 13'd82 || mem_b.char_addr == 13'd0) ? tb_code : 7'h00;
    assign mem_a.glyph_row = (mem_a.glyph_addr == 9'h138) ? 8'h18 :
                             (mem_a.glyph_addr[8:3] == 6'h00) ? 8'h00 : 8'hFF;
    assign mem_b.glyph_row = (mem_b.glyph_addr == 9'h138) ? 8'h18 :
                             (mem_b.glyph_addr[8:3] == 6'h00) ? 8'h00 : 8'hFF;

    glyph_pixel_gen #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) dut_a (
        .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv), .px_valid(px_valid),
        .frame_start(frame_start), .bit_alarma(bit_alarma), .blink_en(blink_en),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .mem(mem_a.master), .BIT_FUENTE(bit_a), .bit_valid(valid_a), .blink_phase(phase_a)
    );

    glyph_pixel_gen #(.SCALE_LOG2(1)) dut_b (
        .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv), .px_valid(px_valid),
        .frame_start(frame_start), .bit_alarma(bit_alarma), .blink_en(blink_en),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .mem(mem_b.master), .BIT_FUENTE(bit_b), .bit_valid(valid_b), .blink_phase(phase_b)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    // Streams n pixels (Qh0.., qv). Pixel alarm_idx gets bit_alarma, pixel
    // nv_idx gets px_valid=0. Outputs are captured per pixel at the falling
    // edges following each pipeline stage.
    task automatic drive_line(input int qh0, input int qv, input int n,
                              input int alarm_idx, input int nv_idx);
        for (int c = 0; c < n + 3; c++) begin
            @(negedge reloj);
            if (c >= 1 && c - 1 < n) begin
                caddr_a[c-1] = mem_a.char_addr;
                caddr_b[c-1] = mem_b.char_addr;
            end
            if (c >= 2 && c - 2 < n) begin
                gaddr_a[c-2] = mem_a.glyph_addr;
                gaddr_b[c-2] = mem_b.glyph_addr;
            end
            if (c >= 3) begin
                obs_a[c-3] = bit_a;
                obs_b[c-3] = bit_b;
                vld_a[c-3] = valid_a;
                vld_b[c-3] = valid_b;
            end
            if (c < n) begin
                Qh         = 10'(qh0 + c);
                Qv         = 10'(qv);
                px_valid   = (c != nv_idx);
                bit_alarma = (c == alarm_idx);
            end else begin
                px_valid   = 1'b0;
                bit_alarma = 1'b0;
            end
        end
    endtask

    task automatic pulse_frames(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge reloj);
            frame_start = 1'b1;
            @(negedge reloj);
            frame_start = 1'b0;
        end
    endtask

    task automatic check_line_a(input string name, input logic [7:0] pat);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs_a[i] !== pat[7-i]) begin
                errors++;
                $display("FAIL %s bit[%0d]: got %b expected %b", name, i, obs_a[i], pat[7-i]);
            end
            checks++;
            if (vld_a[i] !== 1'b1) begin
                errors++;
                $display("FAIL %s valid[%0d]: got %b expected 1", name, i, vld_a[i]);
            end
        end
    endtask

    task automatic test_reset();
        resetM = 1'b1;
        Qh = 10'd19; Qv = 10'd8; px_valid = 1'b1;
        repeat (4) @(negedge reloj);
        checks++;
        if ({bit_a, valid_a, phase_a, bit_b, valid_b, phase_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bit_a, valid_a, phase_a, bit_b, valid_b, phase_b});
        end
        checks++;
        if (mem_a.char_addr !== 13'd0 || mem_a.glyph_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset_addr: got char %0d glyph %0h expected 0 0",
                     mem_a.char_addr, mem_a.glyph_addr);
        end
        px_valid = 1'b0;
        resetM   = 1'b0;
    endtask

    task automatic test_fetch();
        drive_line(16, 8, 8, -1, -1);
        checks++;
        if (caddr_a[0] !== 13'd82) begin
            errors++;
            $display("FAIL fetch_char_addr: got %0d expected 82", caddr_a[0]);
        end
        checks++;
        if (gaddr_a[0] !== 9'h138) begin
            errors++;
            $display("FAIL fetch_glyph_addr: got %0h expected 138", gaddr_a[0]);
        end
        check_line_a("fetch", 8'h18);
    endtask

    task automatic test_alarm();
        drive_line(16, 8, 8, 3, -1);
        check_line_a("alarm", 8'h08);
    endtask

    task automatic test_scaling();
        logic [7:0] pat;
        pat = 8'h18;
        drive_line(32, 16, 16, -1, -1);
        checks++;
        if (caddr_b[0] !== 13'd82 || caddr_b[15] !== 13'd82) begin
            errors++;
            $display("FAIL scale_char_addr: got %0d/%0d expected 82", caddr_b[0], caddr_b[15]);
        end
        checks++;
        if (gaddr_b[0] !== 9'h138) begin
            errors++;
            $display("FAIL scale_glyph_addr: got %0h expected 138", gaddr_b[0]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs_b[i] !== pat[7 - i/2] || vld_b[i] !== 1'b1) begin
                errors++;
                $display("FAIL scale bit[%0d]: got %b/%b expected %b/1",
                         i, obs_b[i], vld_b[i], pat[7 - i/2]);
            end
        end
    endtask

    task automatic check_phase(input string name, input logic exp);
        checks++;
        if (phase_a !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, phase_a, exp);
        end
    endtask

    task automatic test_blink();
        tb_code  = 7'h67;
        blink_en = 1'b1;
        pulse_frames(1);
        check_phase("blink_phase_1pulse", 1'b0);
        pulse_frames(1);
        check_phase("blink_phase_2pulse", 1'b1);
        drive_line(16, 8, 8, -1, -1);
        checks++;
        if (gaddr_a[0] !== 9'h138) begin
            errors++;
            $display("FAIL blink_glyph_addr: got %0h expected 138", gaddr_a[0]);
        end
        check_line_a("blink_off", 8'h00);
        pulse_frames(1);
        check_phase("blink_phase_3pulse", 1'b1);
        pulse_frames(1);
        check_phase("blink_phase_4pulse", 1'b0);
        drive_line(16, 8, 8, -1, -1);
        check_line_a("blink_on", 8'h18);
    endtask

    task automatic test_cursor();
        tb_code  = 7'h27;
        blink_en = 1'b0;
        pulse_frames(2);
        check_phase("cursor_phase", 1'b1);
        cursor_en  = 1'b1;
        cursor_col = 7'd2;
        cursor_row = 6'd1;
        drive_line(16, 8, 8, -1, -1);
        check_line_a("cursor", 8'hE7);
        tb_code  = 7'h67;
        blink_en = 1'b1;
        drive_line(16, 8, 8, -1, -1);
        check_line_a("cursor_over_blink", 8'hFF);
        tb_code  = 7'h27;
        blink_en = 1'b0;
    endtask

    task automatic test_out_of_range();
        drive_line(16, 480, 8, -1, 5);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (caddr_a[i] !== 13'd0) begin
                errors++;
                $display("FAIL oor_char_addr[%0d]: got %0d expected 0", i, caddr_a[i]);
            end
            checks++;
            if (obs_a[i] !== 1'b0 || vld_a[i] !== (i != 5)) begin
                errors++;
                $display("FAIL oor bit/valid[%0d]: got %b/%b expected 0/%b",
                         i, obs_a[i], vld_a[i], (i != 5));
            end
        end
    endtask

    task automatic test_async_reset();
        cursor_en = 1'b0;
        @(negedge reloj);
        Qh = 10'd19; Qv = 10'd8; px_valid = 1'b1;
        repeat (3) @(negedge reloj);
        checks++;
        if (bit_a !== 1'b1 || phase_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got bit %b phase %b expected 1 1", bit_a, phase_a);
        end
        #2 resetM = 1'b1;
        #1;
        checks++;
        if ({bit_a, valid_a, phase_a} !== 3'b000 || mem_a.char_addr !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got bit/valid/phase %b addr %0d expected 000 0",
                     {bit_a, valid_a, phase_a}, mem_a.char_addr);
        end
        @(negedge reloj);
        resetM = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge reloj);
            checks++;
            if (bit_a !== (k == 2) || valid_a !== (k == 2)) begin
                errors++;
                $display("FAIL post_reset[%0d]: got %b/%b expected %b/%b",
                         k, bit_a, valid_a, (k == 2), (k == 2));
            end
        end
        px_valid = 1'b0;
    endtask

    initial begin
        resetM = 1'b1; Qh = '0; Qv = '0; px_valid = 1'b0; frame_start = 1'b0;
        bit_alarma = 1'b0; blink_en = 1'b0; cursor_en = 1'b0;
        cursor_col = '0; cursor_row = '0; tb_code = 7'h27;
        test_reset();
        test_fetch();
        test_alarm();
        test_scaling();
        test_blink();
        test_cursor();
        test_out_of_range();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
